// File: rtl/pipe_latch_param_if.sv
// Pipeline-boundary handshake bundle: advance/stall/flush controls, upstream entry,
// and the registered last-stage view plus the stall-cycle counter.
// DATA_W and CNT_W must match the parameters of the attached pipe_latch_param.
interface pipe_latch_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) ();
  logic              ihit;
  logic              dhit;
  logic              stall_req;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_halt;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_halt;
  logic [CNT_W-1:0]  stall_cycles;

  // Upstream / control side
  modport master (
    output ihit, dhit, stall_req, flush, in_valid, in_data, in_halt,
    input  out_valid, out_data, out_halt, stall_cycles
  );

  // Latch side
  modport slave (
    input  ihit, dhit, stall_req, flush, in_valid, in_data, in_halt,
    output out_valid, out_data, out_halt, stall_cycles
  );
endinterface

// File: rtl/pipe_latch_param.sv
// Parametrised pipeline-boundary register: STAGES back-to-back payload registers with
// valid/halt bits, hit-gated advance, stall hold, flush-to-bubble, sticky halt and a
// saturating stall-cycle counter. All outputs come straight from flops.
module pipe_latch_param #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned STAGES         = 1,
  parameter int unsigned CNT_W          = 16,
  parameter bit          ZERO_ON_BUBBLE = 1'b1
) (
  input logic              CLK,
  input logic              RST,
  pipe_latch_param_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic              halt;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t           stageQ [STAGES];
  stage_t           stageD [STAGES];
  logic             outHaltQ, outHaltD;
  logic [CNT_W-1:0] stallCntQ, stallCntD;
  logic             hit, en, countStall;

  // Advance enable and stall-count qualifier; a cycle without any hit is a memory wait.
  always_comb begin
    hit        = bus.ihit | bus.dhit;
    en         = hit & ~bus.stall_req & ~outHaltQ;
    countStall = ~bus.flush & bus.stall_req & hit;
  end

  // Next stage contents: flush beats advance, otherwise hold.
  always_comb begin
    stageD = stageQ;
    if (bus.flush) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        stageD[k].valid = 1'b0;
        stageD[k].halt  = 1'b0;
        if (ZERO_ON_BUBBLE) stageD[k].data = '0;
      end
    end else if (en) begin
      for (int unsigned k = 1; k < STAGES; k++) begin
        stageD[k] = stageQ[k-1];
      end
      stageD[0].valid = bus.in_valid;
      stageD[0].halt  = bus.in_halt & bus.in_valid;
      if (bus.in_valid) begin
        stageD[0].data = bus.in_data;
      end else if (ZERO_ON_BUBBLE) begin
        stageD[0].data = '0;
      end
    end
  end

  // Sticky halt is set from the next last-stage halt so it rises with the halting entry.
  always_comb begin
    outHaltD  = outHaltQ | stageD[STAGES-1].halt;
    stallCntD = stallCntQ;
    if (countStall && (stallCntQ != {CNT_W{1'b1}})) begin
      stallCntD = stallCntQ + 1'b1;
    end
  end

  // State registers with synchronous reset overriding everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        stageQ[k] <= '0;
      end
      outHaltQ  <= 1'b0;
      stallCntQ <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        stageQ[k] <= stageD[k];
      end
      outHaltQ  <= outHaltD;
      stallCntQ <= stallCntD;
    end
  end

  assign bus.out_valid    = stageQ[STAGES-1].valid;
  assign bus.out_data     = stageQ[STAGES-1].data;
  assign bus.out_halt     = outHaltQ;
  assign bus.stall_cycles = stallCntQ;

endmodule

// File: tb/tb_pipe_latch_param.sv
// Bench for pipe_latch_param: two instances (3 stages / 4-bit counter / zeroed bubbles,
// and 2 stages / 16-bit counter / held bubble data) driven by the same stimulus and
// compared against directed expectations and a behavioural model.
module tb_pipe_latch_param;
  localparam int unsigned AStages = 3;
  localparam int unsigned ACntW   = 4;
  localparam int unsigned BStages = 2;
  localparam int unsigned BCntW   = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, stall_req, flush, in_valid, in_halt;
  logic [31:0] in_data;

  pipe_latch_param_if #(.DATA_W(32), .CNT_W(ACntW)) busA ();
  pipe_latch_param_if #(.DATA_W(32), .CNT_W(BCntW)) busB ();

  assign busA.ihit = ihit;      assign busB.ihit = ihit;
  assign busA.dhit = dhit;      assign busB.dhit = dhit;
  assign busA.stall_req = stall_req;  assign busB.stall_req = stall_req;
  assign busA.flush = flush;    assign busB.flush = flush;
  assign busA.in_valid = in_valid;    assign busB.in_valid = in_valid;
  assign busA.in_data = in_data;      assign busB.in_data = in_data;
  assign busA.in_halt = in_halt;      assign busB.in_halt = in_halt;

  pipe_latch_param #(
    .DATA_W(32), .STAGES(AStages), .CNT_W(ACntW), .ZERO_ON_BUBBLE(1'b1)
  ) dutA (.CLK(CLK), .RST(RST), .bus(busA));

  pipe_latch_param #(
    .DATA_W(32), .STAGES(BStages), .CNT_W(BCntW), .ZERO_ON_BUBBLE(1'b0)
  ) dutB (.CLK(CLK), .RST(RST), .bus(busB));

  always #5 CLK = ~CLK;

  // Model: slot 0 is the newest entry, slot depth-1 is what the outputs show.
  typedef struct packed {
    logic [3:0]       v;
    logic [3:0][31:0] d;
    logic [3:0]       h;
    logic             oh;
    int unsigned      cnt;
  } model_t;

  model_t      mA, mB;
  int unsigned checks = 0;
  int unsigned passed = 0;

  function automatic model_t model_step(model_t m, int unsigned depth, bit zob,
                                        int unsigned cntMax);
    model_t n = m;
    if (RST) begin
      n = '0;
      return n;
    end
    if (flush) begin
      n.v = '0;
      n.h = '0;
      if (zob) n.d = '0;
    end else begin
      if (stall_req && (ihit || dhit) && n.cnt < cntMax) n.cnt++;
      if ((ihit || dhit) && !stall_req && !m.oh) begin
        for (int k = 3; k > 0; k--) begin
          n.v[k] = m.v[k-1];
          n.d[k] = m.d[k-1];
          n.h[k] = m.h[k-1];
        end
        n.v[0] = in_valid;
        n.h[0] = in_valid && in_halt;
        if (in_valid) n.d[0] = in_data;
        else if (zob) n.d[0] = '0;
      end
    end
    n.oh = n.oh | n.h[depth-1];
    return n;
  endfunction

  function automatic logic [37:0] expA();
    return {mA.v[AStages-1], mA.d[AStages-1], mA.oh, mA.cnt[3:0]};
  endfunction
  function automatic logic [37:0] actA();
    return {busA.out_valid, busA.out_data, busA.out_halt, busA.stall_cycles};
  endfunction
  function automatic logic [49:0] expB();
    return {mB.v[BStages-1], mB.d[BStages-1], mB.oh, mB.cnt[15:0]};
  endfunction
  function automatic logic [49:0] actB();
    return {busB.out_valid, busB.out_data, busB.out_halt, busB.stall_cycles};
  endfunction

  task automatic tick();
    @(posedge CLK);
    mA = model_step(mA, AStages, 1'b1, 15);
    mB = model_step(mB, BStages, 1'b0, 65535);
    #1;
  endtask

  task automatic set_idle();
    ihit = 0; dhit = 0; stall_req = 0; flush = 0;
    in_valid = 0; in_halt = 0; in_data = '0;
  endtask

  task automatic do_reset();
    set_idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    RST = 1'b1; ihit = 1; in_valid = 1; in_halt = 1; in_data = 32'hDEADBEEF;
    tick();
    tick();
    checks++;
    if (actA() !== 38'h0)
      $display("FAIL reset_a: got %h expected 0", actA());
    else passed++;
    checks++;
    if (actB() !== 50'h0)
      $display("FAIL reset_b: got %h expected 0", actB());
    else passed++;
    RST = 1'b0;
    set_idle();
  endtask

  task automatic test_latency();
    logic       expV;
    logic [31:0] expD;
    do_reset();
    ihit = 1;
    for (int i = 0; i < 7; i++) begin
      in_valid = (i < 3);
      in_data  = (i < 3) ? 32'(i + 1) : $urandom;
      tick();
      expV = (i >= 2 && i <= 4);
      expD = expV ? 32'(i - 1) : 32'h0;
      checks++;
      if (busA.out_valid !== expV || busA.out_data !== expD)
        $display("FAIL latency_a[%0d]: got v=%b d=%h expected v=%b d=%h",
                 i, busA.out_valid, busA.out_data, expV, expD);
      else passed++;
      checks++;
      if (actB() !== expB())
        $display("FAIL latency_b[%0d]: got %h expected %h", i, actB(), expB());
      else passed++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    ihit = 1; in_valid = 1; in_data = 32'hA5;
    tick();
    in_valid = 0; in_data = $urandom; stall_req = 1;
    repeat (4) tick();
    checks++;
    if (busA.stall_cycles !== 4'd4 || busB.stall_cycles !== 16'd4 || busA.out_valid !== 1'b0)
      $display("FAIL stall_count: got a=%0d b=%0d va=%b expected 4 4 0",
               busA.stall_cycles, busB.stall_cycles, busA.out_valid);
    else passed++;
    stall_req = 0;
    tick();
    checks++;
    if (busB.out_valid !== 1'b1 || busB.out_data !== 32'hA5)
      $display("FAIL stall_release_b: got v=%b d=%h expected 1 a5", busB.out_valid, busB.out_data);
    else passed++;
    tick();
    checks++;
    if (busA.out_valid !== 1'b1 || busA.out_data !== 32'hA5)
      $display("FAIL stall_release_a: got v=%b d=%h expected 1 a5", busA.out_valid, busA.out_data);
    else passed++;
  endtask

  task automatic test_mem_wait();
    logic [37:0] snapA;
    logic [49:0] snapB;
    do_reset();
    ihit = 1; in_valid = 1; in_data = 32'h10;
    tick();
    in_data = 32'h20;
    tick();
    snapA = actA();
    snapB = actB();
    ihit = 0; dhit = 0;
    repeat (5) begin
      in_data = $urandom;
      tick();
    end
    checks++;
    if (actA() !== snapA || actA() !== expA())
      $display("FAIL memwait_a: got %h expected %h", actA(), expA());
    else passed++;
    checks++;
    if (actB() !== snapB || actB() !== expB())
      $display("FAIL memwait_b: got %h expected %h", actB(), expB());
    else passed++;
    dhit = 1; in_valid = 0;
    tick();
    checks++;
    if (busA.out_valid !== 1'b1 || busA.out_data !== 32'h10)
      $display("FAIL memwait_dhit_a: got v=%b d=%h expected 1 10", busA.out_valid, busA.out_data);
    else passed++;
  endtask

  task automatic test_flush_stall();
    do_reset();
    ihit = 1; in_valid = 1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    flush = 1; stall_req = 1; in_data = 32'h33;
    tick();
    checks++;
    if (actA() !== 38'h0)
      $display("FAIL flush_a: got %h expected 0", actA());
    else passed++;
    checks++;
    if (busB.out_valid !== 1'b0 || busB.out_data !== 32'h11 || busB.stall_cycles !== 16'd0)
      $display("FAIL flush_b: got v=%b d=%h c=%0d expected 0 11 0",
               busB.out_valid, busB.out_data, busB.stall_cycles);
    else passed++;
    flush = 0; stall_req = 0; in_valid = 0;
    repeat (3) tick();
    checks++;
    if (busA.out_valid !== 1'b0 || busB.out_valid !== 1'b0 || actB() !== expB())
      $display("FAIL flush_discard: got va=%b vb=%b b=%h expected 0 0 %h",
               busA.out_valid, busB.out_valid, actB(), expB());
    else passed++;
  endtask

  task automatic test_halt();
    do_reset();
    ihit = 1; in_valid = 1; in_halt = 1; in_data = 32'hCAFE;
    tick();
    in_halt = 0; in_data = 32'hBEEF;
    tick();
    checks++;
    if (busB.out_halt !== 1'b1 || busB.out_data !== 32'hCAFE || busA.out_halt !== 1'b0)
      $display("FAIL halt_b_rise: got hb=%b db=%h ha=%b expected 1 cafe 0",
               busB.out_halt, busB.out_data, busA.out_halt);
    else passed++;
    tick();
    checks++;
    if (busA.out_halt !== 1'b1 || busA.out_valid !== 1'b1 || busA.out_data !== 32'hCAFE)
      $display("FAIL halt_a_rise: got h=%b v=%b d=%h expected 1 1 cafe",
               busA.out_halt, busA.out_valid, busA.out_data);
    else passed++;
    repeat (3) begin
      in_data = $urandom;
      tick();
    end
    checks++;
    if (busA.out_data !== 32'hCAFE || busB.out_data !== 32'hCAFE || busA.out_halt !== 1'b1)
      $display("FAIL halt_freeze: got da=%h db=%h ha=%b expected cafe cafe 1",
               busA.out_data, busB.out_data, busA.out_halt);
    else passed++;
    flush = 1;
    tick();
    checks++;
    if (busA.out_halt !== 1'b1 || busB.out_halt !== 1'b1 || busA.out_valid !== 1'b0)
      $display("FAIL halt_flush: got ha=%b hb=%b va=%b expected 1 1 0",
               busA.out_halt, busB.out_halt, busA.out_valid);
    else passed++;
    flush = 0;
    RST = 1;
    tick();
    RST = 0;
    checks++;
    if (busA.out_halt !== 1'b0 || busB.out_halt !== 1'b0)
      $display("FAIL halt_reset: got ha=%b hb=%b expected 0 0", busA.out_halt, busB.out_halt);
    else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    ihit = 1; stall_req = 1;
    repeat (20) tick();
    checks++;
    if (busA.stall_cycles !== 4'd15 || busB.stall_cycles !== 16'd20)
      $display("FAIL saturation: got a=%0d b=%0d expected 15 20",
               busA.stall_cycles, busB.stall_cycles);
    else passed++;
    set_idle();
  endtask

  task automatic test_random();
    int unsigned badA = 0;
    int unsigned badB = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      RST       = ($urandom_range(39) == 0);
      flush     = ($urandom_range(14) == 0);
      stall_req = ($urandom_range(3) == 0);
      ihit      = ($urandom_range(2) != 0);
      dhit      = ($urandom_range(3) == 0);
      in_valid  = $urandom_range(1);
      in_halt   = ($urandom_range(24) == 0);
      in_data   = $urandom;
      tick();
      checks++;
      if (actA() !== expA()) begin
        if (badA < 5) $display("FAIL random_a[%0d]: got %h expected %h", i, actA(), expA());
        badA++;
      end else passed++;
      checks++;
      if (actB() !== expB()) begin
        if (badB < 5) $display("FAIL random_b[%0d]: got %h expected %h", i, actB(), expB());
        badB++;
      end else passed++;
    end
    RST = 0;
    set_idle();
  endtask

  initial begin
    mA = '0;
    mB = '0;
    RST = 1'b0;
    set_idle();
    test_reset();
    test_latency();
    test_stall();
    test_mem_wait();
    test_flush_stall();
    test_halt();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pipe_latch_param.md
Name: pipe_latch_param

Overview:
- Parametrised pipeline-boundary register, successor to the fixed EX/MEM latch.
- Carries an arbitrary-width payload through STAGES back-to-back registers, each with a valid bit.
- Supports hit-gated advance, stall hold and flush-to-bubble.
- Provides a sticky halt that freezes the pipe, plus a saturating stall-cycle counter for performance bring-up. Used for IF/ID, ID/EX, EX/MEM and MEM/WB boundaries.

Parameters:
DATA_W, 32, payload width in bits (1..256)
STAGES, 1, number of register stages in series (1..4)
CNT_W, 16, stall counter width
ZERO_ON_BUBBLE, 1, 1 = a bubble's data is forced to 0; 0 = data held and only valid cleared

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous reset, active-high
ihit  input  1  instruction hit; permits advance
dhit  input  1  data hit; permits advance
stall_req  input  1  hazard-unit stall; holds all stages
flush  input  1  squash all stages to bubbles
in_valid  input  1  upstream entry valid
in_data  input  DATA_W  upstream payload
in_halt  input  1  upstream halt flag
out_valid  output  1  last stage valid
out_data  output  DATA_W  last stage payload
out_halt  output  1  sticky halt, from last stage
stall_cycles  output  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (RST=1 at posedge): all stage valid=0, data=0, halt=0; out_halt=0; stall_cycles=0. RST overrides every other input, including a pending flush or a sticky halt.
- en = (ihit | dhit) & ~stall_req & ~out_halt.
- Priority per posedge: RST > flush > en > hold.
- flush=1:
  - Every stage: valid<=0; data<=0 if ZERO_ON_BUBBLE, else data unchanged; stage halt<=0.
  - The sticky out_halt register is not cleared by flush.
- en=1 (no flush):
  - stage[0] <= {in_valid, in_data, in_halt & in_valid}; stage[k] <= stage[k-1] for k=1..STAGES-1.
  - If in_valid=0, stage[0] data follows the ZERO_ON_BUBBLE rule.
- en=0 (no flush): all stages hold. This is a pure hold; no bubble is inserted.
- Latency: an entry appears at the outputs after exactly STAGES enabled edges. Disabled cycles add delay but never drop or duplicate an entry.
- Outputs are registered: out_valid/out_data = stage[STAGES-1].
- out_halt:
  - Set when stage[STAGES-1].halt becomes 1 (visible the same cycle as the halting entry at the output).
  - Stays 1 until RST.
  - While 1, en is forced to 0, so the pipe freezes with the halting entry at the output.
- stall_cycles: +1 on each posedge where RST=0, flush=0, stall_req=1 and (ihit|dhit)=1. Saturates at 2^CNT_W-1 with no wrap. Cycles without a hit are memory waits and are not counted.
- Simultaneous flush and stall_req: flush wins; no count.
- Simultaneous flush and in_valid: the incoming entry is discarded.
- in_halt with in_valid=0 is ignored.
- STAGES=1 with ZERO_ON_BUBBLE=1 is bit-equivalent to the legacy EX/MEM latch, with a payload bus replacing individual fields.
- No combinational path from any input to any output.

Test Plan:
- Reset: RST=1 for 2 cycles with in_valid=1, in_data=0xDEADBEEF, ihit=1 -> out_valid=0, out_data=0, out_halt=0, stall_cycles=0.
- Latency (STAGES=3): ihit=1 constantly; feed 0x1, 0x2, 0x3 on consecutive cycles -> out_data=0x1 on the 3rd edge after entry, then 0x2, 0x3; out_valid=1 for exactly those 3 cycles.
- Stall (STAGES=2): entry 0xA5 in stage0, stall_req=1 with ihit=1 for 4 cycles -> both stages frozen, stall_cycles=4. Release -> 0xA5 at output one edge later.
- Memory wait: ihit=dhit=0 for 5 cycles with data in flight -> stages hold, stall_cycles unchanged.
- Flush vs stall (STAGES=2, ZERO_ON_BUBBLE=1): stages hold 0x11/0x22, flush=1 and stall_req=1 the same cycle -> both valid=0, data=0, stall_cycles not incremented.
- Sticky halt and saturation (CNT_W=4): entry with in_halt=1 reaches output -> out_halt=1, later inputs ignored and out_data held, flush leaves out_halt=1, RST clears it. Separately, 20 counted stalls -> stall_cycles=15.
